// File: rtl/div_pkg.sv
// div_pkg: shared divider state encodings, handshake levels and widths
package div_pkg;
  localparam int DIV_DATA_W = 32;
  localparam int DIV_CNT_W = $clog2(DIV_DATA_W) + 1;
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;
  localparam logic DIV_RESULT_READY = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP = 1'b0;
  typedef logic [2*DIV_DATA_W-1:0] double_reg_bus_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring division iteration
//  rem_i/quot_i : current partial remainder and shifting dividend/quotient
//  dvsr_i       : divisor magnitude
//  rem_o/quot_o : pair after one shift-and-trial-subtract step
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quot_i,
  input  logic [W-1:0] dvsr_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quot_o
);
  logic [W:0] shifted, trial;
  always_comb begin
    shifted = {rem_i, quot_i[W-1]};
    trial = shifted - {1'b0, dvsr_i};
    rem_o = trial[W] ? shifted[W-1:0] : trial[W-1:0];
    quot_o = {quot_i[W-2:0], ~trial[W]};
  end
endmodule

// File: rtl/div.sv
// div: multi-cycle restoring DIV/DIVU unit answering EX-stage requests
//  clk, rst                 : clock, synchronous active-high reset
//  signed_div_i             : 1 = signed DIV, 0 = DIVU
//  opdata1_i / opdata2_i    : dividend / divisor, sampled on acceptance only
//  start_i / annul_i        : request (held until ready_o) / abort in flight
//  result_o                 : {remainder, quotient}, valid while ready_o
//  ready_o                  : registered result-valid flag
module div
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);
  localparam int CNT_W = $clog2(DATA_W) + 1;
  div_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d, quot_q, quot_d, dvsr_q, dvsr_d;
  logic [DATA_W-1:0] rem_nx, quot_nx, op1_abs, op2_abs, quot_fix, rem_fix;
  logic neg_quot_q, neg_quot_d, neg_rem_q, neg_rem_d, ready_q, ready_d;
  logic [2*DATA_W-1:0] result_q, result_d;

  div_step #(.W(DATA_W)) u_step (
    .rem_i (rem_q),
    .quot_i(quot_q),
    .dvsr_i(dvsr_q),
    .rem_o (rem_nx),
    .quot_o(quot_nx)
  );

  always_comb begin
    op1_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    op2_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    // quotient sign follows the operand signs, remainder follows the dividend
    quot_fix = neg_quot_q ? -quot_q : quot_q;
    rem_fix = neg_rem_q ? -rem_q : rem_q;
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quot_d = quot_q;
    dvsr_d = dvsr_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d = neg_rem_q;
    ready_d = ready_q;
    result_d = result_q;
    case (state_q)
      DIV_FREE: if (start_i == DIV_START && !annul_i) begin
        state_d = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
        cnt_d = '0;
        rem_d = '0;
        quot_d = op1_abs;
        dvsr_d = op2_abs;
        neg_quot_d = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
        neg_rem_d = signed_div_i & opdata1_i[DATA_W-1];
      end
      DIV_BY_ZERO: begin
        state_d = DIV_END;
        result_d = '0;
        ready_d = DIV_RESULT_READY;
      end
      DIV_ON: if (annul_i || start_i == DIV_STOP) begin
        state_d = DIV_FREE;
      end else if (cnt_q == CNT_W'(DATA_W)) begin
        state_d = DIV_END;
        result_d = {rem_fix, quot_fix};
        ready_d = DIV_RESULT_READY;
      end else begin
        rem_d = rem_nx;
        quot_d = quot_nx;
        cnt_d = cnt_q + CNT_W'(1);
      end
      DIV_END: if (start_i == DIV_STOP) begin
        state_d = DIV_FREE;
        ready_d = DIV_RESULT_NOT_READY;
        result_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_FREE;
      cnt_q <= '0;
      rem_q <= '0;
      quot_q <= '0;
      dvsr_q <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_q <= DIV_RESULT_NOT_READY;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quot_q <= quot_d;
      dvsr_q <= dvsr_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q <= neg_rem_d;
      ready_q <= ready_d;
      result_q <= result_d;
    end
  end

  assign ready_o = ready_q;
  assign result_o = result_q;
endmodule

// File: tb/tb_div.sv
// tb_div: randomized and directed checks of div against an arithmetic model
module tb_div;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0, opdata2_i = '0;
  logic start_i = 1'b0, annul_i = 1'b0;
  logic [63:0] result_o;
  logic ready_o;
  logic exp_ready = 1'b0;
  logic [63:0] exp_res = '0;
  int n_checks = 0, n_fail = 0;

  div #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    if (b == 32'd0) return 64'd0;
    ma = (s && a[31]) ? -a : a;
    mb = (s && b[31]) ? -b : b;
    q = ma / mb;
    r = ma % mb;
    if (s && (a[31] ^ b[31])) q = -q;
    if (s && a[31]) r = -r;
    return {r, q};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("ready_o", {63'd0, ready_o}, {63'd0, exp_ready});
    check("result_o", result_o, exp_ready ? exp_res : 64'd0);
  end

  // mode 0: complete, 1: annul pulse after step, 2: start dropped after step
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input int mode, input int step, input int hold);
    int lat;
    lat = (b == 32'd0) ? 1 : 33;
    signed_div_i = s;
    opdata1_i = a;
    opdata2_i = b;
    annul_i = 1'b0;
    start_i = 1'b1;
    @(posedge clk); #1;
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    signed_div_i = 1'($urandom);
    if (mode != 0 && b != 32'd0) begin
      repeat (step) @(posedge clk);
      #1;
      if (mode == 1) annul_i = 1'b1;
      else start_i = 1'b0;
      @(posedge clk); #1;
      annul_i = 1'b0;
      start_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end else begin
      repeat (lat - 1) @(posedge clk);
      #1;
      exp_res = model(s, a, b);
      @(posedge clk); #1;
      exp_ready = 1'b1;
      repeat (hold) begin
        annul_i = 1'($urandom);
        @(posedge clk); #1;
      end
      annul_i = 1'b0;
      start_i = 1'b0;
      @(posedge clk); #1;
      exp_ready = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] a, b;
    check("model 100/7 u", model(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
    check("model -7/2 s", model(1'b1, 32'hFFFFFFF9, 32'd2), {32'hFFFFFFFF, 32'hFFFFFFFD});
    check("model 7/-2 s", model(1'b1, 32'd7, 32'hFFFFFFFE), {32'd1, 32'hFFFFFFFD});
    check("model ovf s", model(1'b1, 32'h80000000, 32'hFFFFFFFF), {32'd0, 32'h80000000});
    check("model ffff/16 u", model(1'b0, 32'hFFFFFFFF, 32'd16), {32'd15, 32'h0FFFFFFF});
    check("model /0", model(1'b1, 32'd5, 32'd0), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(1'b0, 32'd100, 32'd7, 0, 0, 3);
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, 0, 0, 1);
    run_op(1'b1, 32'd7, 32'hFFFFFFFE, 0, 0, 0);
    run_op(1'b0, 32'd1234, 32'd0, 0, 0, 2);
    run_op(1'b1, 32'h80000001, 32'd0, 0, 0, 0);
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 0, 1);
    run_op(1'b0, 32'd500, 32'd3, 1, 10, 0);
    run_op(1'b0, 32'hFFFFFFFF, 32'd16, 0, 0, 1);
    run_op(1'b1, 32'd99, 32'd5, 2, 31, 0);
    signed_div_i = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    repeat (21) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset ready", {63'd0, ready_o}, 64'd0);
    check("reset result", result_o, 64'd0);
    rst = 1'b0;
    run_op(1'b0, 32'hFFFFFFFF, 32'd16, 0, 0, 1);
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(1, 300);
        2: b = -32'($urandom_range(1, 300));
        3: a = 32'h80000000;
        default: ;
      endcase
      run_op(1'($urandom), a, b, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0,
             $urandom_range(0, 31), $urandom_range(0, 3));
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
